// File: rtl/io_pkg.sv
// Shared types and constants for the CPU-side MMIO initiator (io_master).
package io_pkg;

  localparam int IO_ADDR_W = 8;
  localparam int DATA_W    = 32;

  localparam logic [23:0] IO_BASE_DEFAULT = 24'hFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STROBE = 3'd1,
    S_WAIT   = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } io_state_e;

endpackage

// File: rtl/io_addr_dec.sv
// IO window decoder: flags a CPU byte address that falls in the IO page and is word aligned.
module io_addr_dec
  import io_pkg::*;
(
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [23:0]       io_base,
  output logic              hit,
  output logic              aligned
);

  // The register offset bits play no part in the decode.
  logic unused_offset;

  assign hit           = (cpu_addr[31:8] == io_base);
  assign aligned       = (cpu_addr[1:0] == 2'b00);
  assign unused_offset = ^cpu_addr[7:2];

endmodule

// File: rtl/io_master.sv
// CPU-to-MMIO bus initiator: one-cycle io_we/io_rd strobe, holds the bus until io_ack, stalls CPU via io_busy.
// Optional WAIT timeout abort is built when IO_TIMEOUT_EN is defined.
module io_master
  import io_pkg::*;
#(
  parameter logic [23:0] IO_BASE = IO_BASE_DEFAULT
`ifdef IO_TIMEOUT_EN
  ,
  parameter logic [15:0] TIMEOUT_CYC = 16'hFFFF
`endif
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [DATA_W-1:0]    cpu_addr,
  input  logic [DATA_W-1:0]    cpu_wdata,
  output logic [DATA_W-1:0]    cpu_rdata,
  output logic                 cpu_ack,
  output logic                 cpu_err,
  output logic                 io_busy,
  output logic [IO_ADDR_W-1:0] io_addr,
  output logic [DATA_W-1:0]    io_dout,
  output logic                 io_we,
  output logic                 io_rd,
  input  logic [DATA_W-1:0]    io_din,
  input  logic                 io_ack
);

  io_state_e state;
  logic      we_flag;
  logic      hit;
  logic      aligned;

`ifdef IO_TIMEOUT_EN
  logic [15:0] tcnt;
`endif

  io_addr_dec u_dec (
    .cpu_addr (cpu_addr),
    .io_base  (IO_BASE),
    .hit      (hit),
    .aligned  (aligned)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      we_flag   <= 1'b0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      io_busy   <= 1'b0;
      io_addr   <= '0;
      io_dout   <= '0;
      io_we     <= 1'b0;
      io_rd     <= 1'b0;
`ifdef IO_TIMEOUT_EN
      tcnt      <= '0;
`endif
    end else begin
      // NOTE: pulse outputs default low with non-blocking writes; a later assignment in
      // the case below overrides them, so each pulse lasts exactly the one cycle it is set for.
      io_we   <= 1'b0;
      io_rd   <= 1'b0;
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            io_busy <= 1'b1;
            if (hit && aligned) begin
              io_addr <= cpu_addr[IO_ADDR_W-1:0];
              io_dout <= cpu_wdata;
              we_flag <= cpu_we;
              io_we   <= cpu_we;
              io_rd   <= !cpu_we;
              state   <= S_STROBE;
`ifdef IO_TIMEOUT_EN
              tcnt    <= '0;
`endif
            end else begin
              cpu_ack <= 1'b1;
              cpu_err <= 1'b1;
              state   <= S_ERR;
            end
          end
        end

        // A device may complete in the strobe cycle itself.
        S_STROBE: begin
          if (io_ack) begin
            if (!we_flag) cpu_rdata <= io_din;
            cpu_ack <= 1'b1;
            state   <= S_DONE;
          end else begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (io_ack) begin
            if (!we_flag) cpu_rdata <= io_din;
            cpu_ack <= 1'b1;
            state   <= S_DONE;
          end
`ifdef IO_TIMEOUT_EN
          // io_ack is tested first so it wins over the terminal count.
          else if (tcnt == TIMEOUT_CYC - 16'd1) begin
            cpu_ack <= 1'b1;
            cpu_err <= 1'b1;
            state   <= S_ERR;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
`endif
        end

        S_DONE, S_ERR: begin
          io_busy <= 1'b0;
          state   <= S_IDLE;
        end

        default: begin
          io_busy <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_master.sv
// Directed self-checking bench for io_master; timeout checks follow IO_TIMEOUT_EN.
module tb_io_master;
  import io_pkg::*;

  logic        clk;
  logic        rstn;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        cpu_err;
  logic        io_busy;
  logic [7:0]  io_addr;
  logic [31:0] io_dout;
  logic        io_we;
  logic        io_rd;
  logic [31:0] io_din;
  logic        io_ack;

  int tests;
  int fails;

`ifdef IO_TIMEOUT_EN
  io_master #(.TIMEOUT_CYC(16'd8)) dut (
`else
  io_master dut (
`endif
    .clk       (clk),
    .rstn      (rstn),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .cpu_err   (cpu_err),
    .io_busy   (io_busy),
    .io_addr   (io_addr),
    .io_dout   (io_dout),
    .io_we     (io_we),
    .io_rd     (io_rd),
    .io_din    (io_din),
    .io_ack    (io_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rstn      = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    io_din    = 32'hFFFF_0000;
    io_ack    = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_cpu_err", cpu_err, 0);
    check("rst_io_busy", io_busy, 0);
    check("rst_io_we", io_we, 0);
    check("rst_io_rd", io_rd, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_io_addr", io_addr, 0);
    check("rst_io_dout", io_dout, 0);
    rstn = 1'b1;
    tick();

    // Store to 0xFFFFFF04, device acks 5 cycles after the request
    start_req(1'b1, 32'hFFFF_FF04, 32'h1234_5678);
    tick();
    cpu_req = 1'b0;
    check("st_we_c1", io_we, 1);
    check("st_rd_c1", io_rd, 0);
    check("st_addr_c1", io_addr, 32'h04);
    check("st_dout_c1", io_dout, 32'h1234_5678);
    check("st_busy_c1", io_busy, 1);
    check("st_ack_c1", cpu_ack, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("st_we_wait", io_we, 0);
      check("st_rd_wait", io_rd, 0);
      check("st_addr_wait", io_addr, 32'h04);
      check("st_dout_wait", io_dout, 32'h1234_5678);
      check("st_ack_wait", cpu_ack, 0);
    end
    io_ack = 1'b1;
    tick();
    io_ack = 1'b0;
    check("st_cpu_ack", cpu_ack, 1);
    check("st_cpu_err", cpu_err, 0);
    check("st_busy_ack", io_busy, 1);
    check("st_rdata_kept", cpu_rdata, 0);
    check("st_rd_ack", io_rd, 0);
    tick();
    check("st_ack_drop", cpu_ack, 0);
    check("st_busy_drop", io_busy, 0);

    // Load 0xFFFFFF08 completed in the strobe cycle
    start_req(1'b0, 32'hFFFF_FF08, 32'h0);
    tick();
    cpu_req = 1'b0;
    check("ld_rd_c1", io_rd, 1);
    check("ld_we_c1", io_we, 0);
    check("ld_addr_c1", io_addr, 32'h08);
    io_din = 32'h0000_ABCD;
    io_ack = 1'b1;
    tick();
    io_ack = 1'b0;
    io_din = 32'hDEAD_BEEF;
    check("ld_ack_c2", cpu_ack, 1);
    check("ld_err_c2", cpu_err, 0);
    check("ld_rdata_c2", cpu_rdata, 32'h0000_ABCD);
    check("ld_rd_c2", io_rd, 0);
    tick();
    check("ld_ack_drop", cpu_ack, 0);
    check("ld_rdata_held", cpu_rdata, 32'h0000_ABCD);

    // Decode errors: outside window, then misaligned
    start_req(1'b0, 32'h0000_1000, 32'h0);
    tick();
    cpu_req = 1'b0;
    check("dec_ack", cpu_ack, 1);
    check("dec_err", cpu_err, 1);
    check("dec_we", io_we, 0);
    check("dec_rd", io_rd, 0);
    check("dec_busy", io_busy, 1);
    check("dec_rdata", cpu_rdata, 32'h0000_ABCD);
    tick();
    check("dec_ack_drop", cpu_ack, 0);
    check("dec_busy_drop", io_busy, 0);
    start_req(1'b0, 32'hFFFF_FF02, 32'h0);
    tick();
    cpu_req = 1'b0;
    check("mis_ack", cpu_ack, 1);
    check("mis_err", cpu_err, 1);
    check("mis_we", io_we, 0);
    check("mis_rd", io_rd, 0);
    check("mis_rdata", cpu_rdata, 32'h0000_ABCD);
    tick();
    check("mis_ack_drop", cpu_ack, 0);

    // Stray io_ack in IDLE is ignored
    io_ack = 1'b1;
    tick();
    io_ack = 1'b0;
    check("stray_ack", cpu_ack, 0);
    check("stray_busy", io_busy, 0);
    tick();
    check("stray_ack2", cpu_ack, 0);

    // cpu_req held across cpu_ack starts a back-to-back transaction
    start_req(1'b1, 32'hFFFF_FF10, 32'hAAAA_5555);
    tick();
    check("b2b_we1", io_we, 1);
    check("b2b_addr1", io_addr, 32'h10);
    io_ack = 1'b1;
    tick();
    io_ack = 1'b0;
    check("b2b_ack1", cpu_ack, 1);
    check("b2b_err1", cpu_err, 0);
    check("b2b_we_done", io_we, 0);
    start_req(1'b0, 32'hFFFF_FF14, 32'h0BAD_F00D);
    tick();
    check("b2b_idle_ack", cpu_ack, 0);
    check("b2b_idle_busy", io_busy, 0);
    check("b2b_idle_rd", io_rd, 0);
    tick();
    cpu_req = 1'b0;
    check("b2b_rd2", io_rd, 1);
    check("b2b_we2", io_we, 0);
    check("b2b_addr2", io_addr, 32'h14);
    io_din = 32'hCAFE_F00D;
    io_ack = 1'b1;
    tick();
    io_ack = 1'b0;
    check("b2b_ack2", cpu_ack, 1);
    check("b2b_rdata2", cpu_rdata, 32'hCAFE_F00D);
    tick();
    check("b2b_ack2_drop", cpu_ack, 0);

    // Reset during WAIT, then a late io_ack
    start_req(1'b0, 32'hFFFF_FF20, 32'h0);
    tick();
    cpu_req = 1'b0;
    check("rw_rd", io_rd, 1);
    tick();
    tick();
    check("rw_busy_wait", io_busy, 1);
    rstn = 1'b0;
    #1;
    check("rw_we", io_we, 0);
    check("rw_rd0", io_rd, 0);
    check("rw_busy", io_busy, 0);
    check("rw_ack", cpu_ack, 0);
    check("rw_rdata", cpu_rdata, 0);
    tick();
    rstn = 1'b1;
    io_ack = 1'b1;
    tick();
    io_ack = 1'b0;
    check("rw_late_ack", cpu_ack, 0);
    check("rw_late_busy", io_busy, 0);
    tick();
    check("rw_late_ack2", cpu_ack, 0);

`ifdef IO_TIMEOUT_EN
    // Timeout after 8 WAIT cycles, read data not captured
    io_din = 32'h5A5A_5A5A;
    start_req(1'b0, 32'hFFFF_FF30, 32'h0);
    tick();
    cpu_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("to_wait_ack", cpu_ack, 0);
      check("to_wait_busy", io_busy, 1);
    end
    tick();
    check("to_ack", cpu_ack, 1);
    check("to_err", cpu_err, 1);
    check("to_rdata", cpu_rdata, 0);
    tick();
    check("to_ack_drop", cpu_ack, 0);

    // io_ack on the terminal WAIT cycle wins
    start_req(1'b0, 32'hFFFF_FF34, 32'h0);
    tick();
    cpu_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("tw_wait_ack", cpu_ack, 0);
    end
    io_din = 32'h1357_9BDF;
    io_ack = 1'b1;
    tick();
    io_ack = 1'b0;
    check("tw_ack", cpu_ack, 1);
    check("tw_err", cpu_err, 0);
    check("tw_rdata", cpu_rdata, 32'h1357_9BDF);
    tick();
`else
    // Without the timeout, WAIT holds until the device answers
    io_din = 32'h5A5A_5A5A;
    start_req(1'b0, 32'hFFFF_FF30, 32'h0);
    tick();
    cpu_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("nt_wait_ack", cpu_ack, 0);
      check("nt_wait_busy", io_busy, 1);
    end
    io_din = 32'h1357_9BDF;
    io_ack = 1'b1;
    tick();
    io_ack = 1'b0;
    check("nt_ack", cpu_ack, 1);
    check("nt_err", cpu_err, 0);
    check("nt_rdata", cpu_rdata, 32'h1357_9BDF);
    tick();
`endif
    check("end_busy", io_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/io_master.md
Name: io_master

Overview:
- CPU-side initiator for the 8-bit-address MMIO bus that the debug/control unit serves as device.
- Turns a CPU load/store request inside the IO window into a one-cycle io_we/io_rd strobe.
- Holds io_addr/io_dout stable until the device completes, returns read data to the CPU, and stalls the CPU through io_busy.
- Sits between the CPU memory stage and the IO bus; runs on the 100 MHz board clock.

Parameters:
IO_BASE, 24'hFFFF_FF, cpu_addr[31:8] value selecting the IO window
TIMEOUT_CYC, 16'hFFFF, cycles in WAIT before timeout abort (used only with IO_TIMEOUT_EN)

Ports:
clk  in  1  system clock (clk100mhz)
rstn  in  1  asynchronous active-low reset
cpu_req  in  1  level request from CPU memory stage
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  32  byte address
cpu_wdata  in  32  store data
cpu_rdata  out  32  load data, valid with cpu_ack, held until next cpu_ack
cpu_ack  out  1  one-cycle completion pulse
cpu_err  out  1  qualifies cpu_ack: decode error or timeout
io_busy  out  1  high whenever state != IDLE (CPU stall)
io_addr  out  8  IO register address
io_dout  out  32  write data to device
io_we  out  1  one-cycle write strobe
io_rd  out  1  one-cycle read strobe
io_din  in  32  read data from device
io_ack  in  1  device completion pulse

Behaviour:
- Reset (async, rstn=0): state IDLE. All outputs 0: cpu_rdata, cpu_ack, cpu_err, io_busy, io_addr, io_dout, io_we, io_rd, and the timeout counter. Reset mid-transaction drops strobes immediately; no ack is issued.
- States: IDLE, STROBE, WAIT, DONE, ERR.
- IDLE:
  - cpu_req=1 with cpu_addr[31:8]==IO_BASE and cpu_addr[1:0]==0: latch io_addr<=cpu_addr[7:0], io_dout<=cpu_wdata, we flag<=cpu_we; go to STROBE.
  - cpu_req=1 otherwise: go to ERR.
  - Requests are accepted only in IDLE.
- STROBE: exactly one cycle with io_we=we flag and io_rd=!we flag; go to WAIT. If io_ack=1 in this cycle, go straight to DONE and capture io_din if a read.
- WAIT: strobes are 0; io_addr/io_dout stay stable. On io_ack=1: reads capture cpu_rdata<=io_din; go to DONE.
- DONE: cpu_ack=1, cpu_err=0 for one cycle; go to IDLE. Writes leave cpu_rdata unchanged.
- ERR: cpu_ack=1, cpu_err=1 for one cycle, no bus strobe; cpu_rdata unchanged; go to IDLE.
- cpu_req is level-sensitive. If the CPU holds cpu_req high in the cycle after cpu_ack, IDLE starts a new transaction.
- io_ack in IDLE, DONE or ERR is ignored.
- Latency, with request sampled at cycle 0:
  - STROBE at cycle 1.
  - io_ack sampled at cycle n≥1 gives cpu_ack at cycle n+1, so the minimum is cycle 2.
  - Decode error gives cpu_ack at cycle 1.
- io_busy = (state != IDLE). It is registered with the state, so it is high from cycle 1 through the ack cycle.

Optional Feature:
- IO_TIMEOUT_EN defined:
  - 16-bit counter clears on entry to STROBE and increments each cycle in WAIT.
  - If it reaches TIMEOUT_CYC without io_ack, go to ERR; cpu_rdata is not updated.
  - io_ack in the same cycle as the terminal count wins.
- IO_TIMEOUT_EN undefined: no counter; WAIT holds indefinitely; cpu_err only flags decode errors.

Decomposition:
- Package io_pkg: state encoding constants, IO_BASE default, IO_ADDR_W=8, DATA_W=32.
- One natural sub-module: io_addr_dec, combinational; cpu_addr and IO_BASE in, hit and aligned out.
- The FSM, data latches and timeout counter stay in io_master.

Test Plan:
- Store cpu_addr=32'hFFFF_FF04, wdata=32'h1234_5678: io_we high for exactly 1 cycle, io_addr=8'h04, io_dout=32'h1234_5678 stable until io_ack; io_ack 5 cycles later -> cpu_ack=1, cpu_err=0 the next cycle, io_rd never high.
- Load 32'hFFFF_FF08, device drives io_din=32'h0000_ABCD with io_ack in the STROBE cycle -> cpu_ack at cycle 2, cpu_rdata=32'h0000_ABCD, held after the ack.
- Load 32'h0000_1000 (outside window) and 32'hFFFF_FF02 (misaligned) -> cpu_ack=cpu_err=1 at cycle 1, no io_we/io_rd, cpu_rdata unchanged.
- Stray io_ack in IDLE, then cpu_req held high across cpu_ack -> stray ack ignored; second transaction starts the cycle after DONE with a fresh strobe.
- rstn pulled low during WAIT -> io_we/io_rd/io_busy/cpu_ack at 0 immediately; after release, a late io_ack produces no cpu_ack.
- IO_TIMEOUT_EN, TIMEOUT_CYC=16'd8, no io_ack -> cpu_ack=cpu_err=1 after 8 WAIT cycles; with io_ack on the terminal cycle -> normal completion, cpu_err=0.
